// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, shift-amount width and the opcode map
// used by both the ALU and the decoder/control unit.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_INC    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_MUL    = 5'd3;
  localparam logic [4:0] OP_DEC    = 5'd4;
  localparam logic [4:0] OP_NEG    = 5'd5;
  localparam logic [4:0] OP_SLL    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_ROL    = 5'd9;
  localparam logic [4:0] OP_ROR    = 5'd10;
  localparam logic [4:0] OP_SLT    = 5'd11;
  localparam logic [4:0] OP_SLTU   = 5'd12;
  localparam logic [4:0] OP_NOT    = 5'd13;
  localparam logic [4:0] OP_AND    = 5'd14;
  localparam logic [4:0] OP_OR     = 5'd15;
  localparam logic [4:0] OP_XOR    = 5'd16;
  localparam logic [4:0] OP_NAND   = 5'd17;
  localparam logic [4:0] OP_NOR    = 5'd18;
  localparam logic [4:0] OP_XNOR   = 5'd19;
  localparam logic [4:0] OP_PASS_A = 5'd20;
  localparam logic [4:0] OP_PASS_B = 5'd21;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit: SLL, SRL, SRA, ROL, ROR of a by shamt.
// Non-shift opcodes yield zero so the caller can OR or mux freely.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] sll_val;
  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] sra_val;
  logic [WIDTH-1:0] ror_stage [SHAMT_W+1];
  logic [WIDTH-1:0] rol_stage [SHAMT_W+1];

  assign sll_val = a << shamt;
  assign srl_val = a >> shamt;
  assign sra_val = $signed(a) >>> shamt;

  // Log-depth barrel rotators: stage gi rotates by 2**gi when shamt[gi] is set.
  assign ror_stage[0] = a;
  assign rol_stage[0] = a;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_rot
      localparam int STEP = 1 << gi;
      assign ror_stage[gi+1] = shamt[gi]
        ? {ror_stage[gi][STEP-1:0], ror_stage[gi][WIDTH-1:STEP]}
        : ror_stage[gi];
      assign rol_stage[gi+1] = shamt[gi]
        ? {rol_stage[gi][WIDTH-STEP-1:0], rol_stage[gi][WIDTH-1:WIDTH-STEP]}
        : rol_stage[gi];
    end
  endgenerate

  always_comb begin
    result = '0;
    case (opcode)
      OP_SLL:  result = sll_val;
      OP_SRL:  result = srl_val;
      OP_SRA:  result = sra_val;
      OP_ROL:  result = rol_stage[SHAMT_W];
      OP_ROR:  result = ror_stage[SHAMT_W];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: combinational result from opcode/a/b, captured
// into out on enabled rising edges; asynchronous active-low clear.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] result_next;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] shift_result;
  logic             slt_bit;
  logic             sltu_bit;

  // One shared adder covers ADD/INC/SUB/DEC/NEG via operand and carry-in selection.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (opcode)
      OP_INC: begin
        add_y   = '0;
        add_cin = 1'b1;
      end
      OP_SUB: begin
        add_y   = ~b;
        add_cin = 1'b1;
      end
      OP_DEC: begin
        add_y   = '1;
      end
      OP_NEG: begin
        add_x   = '0;
        add_y   = ~a;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum  = add_x + add_y + {{(WIDTH-1){1'b0}}, add_cin};
  assign mul_lo   = a * b;
  assign slt_bit  = $signed(a) < $signed(b);
  assign sltu_bit = a < b;

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .opcode (opcode),
    .a      (a),
    .shamt  (b[SHAMT_W-1:0]),
    .result (shift_result)
  );

  always_comb begin
    result_next = '0;
    case (opcode)
      OP_ADD, OP_INC, OP_SUB, OP_DEC, OP_NEG: result_next = add_sum;
      OP_MUL:    result_next = mul_lo;
      OP_SLT:    result_next = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU:   result_next = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_NOT:    result_next = ~a;
      OP_AND:    result_next = a & b;
      OP_OR:     result_next = a | b;
      OP_XOR:    result_next = a ^ b;
      OP_NAND:   result_next = ~(a & b);
      OP_NOR:    result_next = ~(a | b);
      OP_XNOR:   result_next = ~(a ^ b);
      OP_PASS_A: result_next = a;
      OP_PASS_B: result_next = b;
      default:   result_next = is_shift_op(opcode) ? shift_result : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if (enable) begin
      out_reg <= result_next;
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal checks plus randomized traffic
// compared every cycle against a behavioural reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        enable = 1'b1;
  logic [31:0] out;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_reg = '0;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .enable (enable),
    .out    (out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0]     r;
    longint unsigned px;
    longint unsigned py;
    longint unsigned prod;
    int              sx;
    int              sy;
    int              sh;
    sh = {27'd0, y[4:0]};
    sx = x;
    sy = y;
    r  = x;
    case (op)
      5'd0:  r = x + y;
      5'd1:  r = x + 32'd1;
      5'd2:  r = x - y;
      5'd3: begin
        px = {32'd0, x};
        py = {32'd0, y};
        prod = px * py;
        r = prod[31:0];
      end
      5'd4:  r = x - 32'd1;
      5'd5:  r = 32'd0 - x;
      5'd6:  for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      5'd7:  for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      5'd8:  for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      5'd9:  for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
      5'd10: for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
      5'd11: r = (sx < sy) ? 32'd1 : 32'd0;
      5'd12: r = (x < y) ? 32'd1 : 32'd0;
      5'd13: r = ~x;
      5'd14: r = x & y;
      5'd15: r = x | y;
      5'd16: r = x ^ y;
      5'd17: r = ~(x & y);
      5'd18: r = ~(x | y);
      5'd19: r = ~(x ^ y);
      5'd20: r = x;
      5'd21: r = y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference register: what out must hold given the edge-sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_reg <= 32'd0;
    else if (enable) exp_reg <= model(opcode, a, b);
  end

  always @(negedge clk) begin
    checks++;
    if (out === exp_reg) passes++;
    else $display("FAIL model_cmp t=%0t out=%08h expected=%08h", $time, out, exp_reg);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s out=%08h expected=%08h", name, got, want);
    $display("chk %-12s op=%0d a=%08h b=%08h en=%0b out=%08h", name, opcode, a, b, enable, got);
  endtask

  task automatic step(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, input logic en);
    @(negedge clk);
    opcode = op;
    a      = x;
    b      = y;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset held with enable=1 and live inputs: edges must load nothing.
    opcode = 5'd20;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    enable = 1'b1;
    #1;
    check("reset_t0", out, 32'h0);
    @(posedge clk); #1;
    check("reset_edge", out, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step(5'd0, 32'h0F0F_0F0F, 32'h0, 1'b1);
    check("add_first", out, 32'h0F0F_0F0F);

    step(5'd14, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1); check("and", out, 32'h0F0F_0F0F);
    step(5'd15, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1); check("or", out, 32'hFFFF_FFFF);
    step(5'd16, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1); check("xor", out, 32'hF0F0_F0F0);
    step(5'd13, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1); check("not", out, 32'hF0F0_F0F0);

    step(5'd3, 32'd45562, 32'd45500, 1'b1);          check("mul", out, 32'd2073071000);
    step(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);          check("add_wrap", out, 32'h0);
    step(5'd2, 32'd0, 32'd1, 1'b1);                  check("sub_wrap", out, 32'hFFFF_FFFF);

    step(5'd8, 32'h8000_0001, 32'd4, 1'b1);          check("sra", out, 32'hF800_0000);
    step(5'd7, 32'h8000_0001, 32'd4, 1'b1);          check("srl", out, 32'h0800_0000);
    step(5'd9, 32'h8000_0001, 32'd4, 1'b1);          check("rol", out, 32'h0000_0018);
    step(5'd10, 32'h8000_0001, 32'hFFFF_FFE4, 1'b1); check("ror_hi_b", out, 32'h1800_0000);
    step(5'd6, 32'h8000_0001, 32'd0, 1'b1);          check("sll_zero", out, 32'h8000_0001);
    step(5'd11, 32'hFFFF_FFFF, 32'd1, 1'b1);         check("slt", out, 32'd1);
    step(5'd12, 32'hFFFF_FFFF, 32'd1, 1'b1);         check("sltu", out, 32'd0);
    step(5'd5, 32'd1, 32'd0, 1'b1);                  check("neg", out, 32'hFFFF_FFFF);
    step(5'd4, 32'd0, 32'd0, 1'b1);                  check("dec_wrap", out, 32'hFFFF_FFFF);

    // Hold: 28 must survive several disabled edges with changing inputs.
    step(5'd2, 32'd4528, 32'd4500, 1'b1);            check("sub", out, 32'd28);
    for (int i = 0; i < 4; i++) begin
      step(5'(i * 5 + 1), $urandom, $urandom, 1'b0);
      check("hold", out, 32'd28);
    end
    step(5'd0, 32'd1, 32'd2, 1'b1);                  check("hold_release", out, 32'd3);

    step(5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); check("reserved", out, 32'h0);

    // Asynchronous clear mid-cycle, then edges with reset low load nothing.
    step(5'd20, 32'hCAFE_F00D, 32'd0, 1'b1);         check("pass_a", out, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1 check("async_rst", out, 32'h0);
    step(5'd21, 32'd0, 32'h1357_9BDF, 1'b1);         check("rst_low_edge", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'd21, 32'd0, 32'h1357_9BDF, 1'b1);         check("post_rst", out, 32'h1357_9BDF);

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      opcode = 5'($urandom_range(0, 31));
      a      = pick_operand();
      b      = pick_operand();
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
